// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-port main-memory arbiter.
package mem_bus_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  // Port 0 = L1 I-cache, port 1 = L1 D-cache.
  typedef logic port_id_t;

  // One-hot completion vector for a port.
  function automatic logic [1:0] port_mask(port_id_t p);
    return p ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mem_bus_rr_arb.sv
// Two-way round-robin grant: the pointer only decides ties; a lone
// requester always wins.
module mem_bus_rr_arb
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   ptr,
  output logic       any,
  output port_id_t   gnt
);

  // Grant selection from the live request vector.
  always_comb begin
    any = |req;
    gnt = ptr;
    if (req == 2'b01)      gnt = 1'b0;
    else if (req == 2'b10) gnt = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one main-memory
// handshake between the I-cache (port 0) and D-cache (port 1).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_store,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_done,
  output logic                   req_err,
  output logic [DATA_W-1:0]      req_rdata,
  output logic                   mem_valid,
  output logic                   mem_store,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack_addr,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_ack_data
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

  state_t        state;
  port_id_t      ptr;
  port_id_t      grant;
  port_id_t      arb_gnt;
  logic          arb_any;
  logic [CW-1:0] tcnt;

  mem_bus_rr_arb u_arb (
    .req (req_valid),
    .ptr (ptr),
    .any (arb_any),
    .gnt (arb_gnt)
  );

  // Sequencer: grant/latch, address phase, data phase with timeout, response.
  // Every output is a register so reset clears them all at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      grant        <= 1'b0;
      tcnt         <= '0;
      req_done     <= '0;
      req_err      <= 1'b0;
      req_rdata    <= '0;
      mem_valid    <= 1'b0;
      mem_store    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_ack_data <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          grant     <= arb_gnt;
          mem_store <= req_store[arb_gnt];
          mem_addr  <= req_addr[arb_gnt];
          mem_wdata <= req_wdata[arb_gnt];
          mem_valid <= 1'b1;
          state     <= ADDR;
        end
        // mem_ready is deliberately ignored here.
        ADDR: if (mem_ack_addr) begin
          mem_valid <= 1'b0;
          tcnt      <= '0;
          state     <= DATA;
        end
        // Ready on the same cycle the count hits the limit still wins.
        DATA: begin
          if (mem_ready) begin
            req_done     <= port_mask(grant);
            req_err      <= 1'b0;
            req_rdata    <= mem_store ? '0 : mem_rdata;
            mem_ack_data <= 1'b1;
            state        <= RESP;
          end else if (tcnt == TMAX) begin
            req_done  <= port_mask(grant);
            req_err   <= 1'b1;
            req_rdata <= '0;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        RESP: begin
          req_done     <= '0;
          req_err      <= 1'b0;
          req_rdata    <= '0;
          mem_ack_data <= 1'b0;
          ptr          <= ~grant;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
